// File: rtl/tqvp_sprite_engine.sv
// TinyQV sprite peripheral: N double-buffered 1bpp sprites composited over an
// external background, with collision and missed-commit interrupts.
module tqvp_sprite_engine #(
    parameter int NUM_SPRITES = 4,
    parameter int BMP_BYTES   = 32,
    parameter int SCALE_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        visible,
    input  logic        vsync,
    input  logic [5:0]  bg_rgb,
    output logic [5:0]  rgb_out,
    output logic        user_interrupt
);

    localparam int OBJ_BYTES   = 4 * NUM_SPRITES;
    localparam int BMP_BASE    = OBJ_BYTES;
    localparam int COL_BASE    = BMP_BASE + BMP_BYTES;
    localparam int COL_END     = COL_BASE + NUM_SPRITES;
    localparam int ADDR_CTRL   = 60;
    localparam int ADDR_STATUS = 61;
    localparam int ADDR_COLL   = 62;
    localparam int ADDR_IRQ_EN = 63;
    localparam int BA_W        = (BMP_BYTES > 1) ? $clog2(BMP_BYTES) : 1;

    if (NUM_SPRITES < 1 || NUM_SPRITES > 8 || 5 * NUM_SPRITES + BMP_BYTES > 60) begin : g_bad_params
        $error("tqvp_sprite_engine: sprite/bitmap sizes do not fit below the control registers");
    end

    // Storage
    logic [7:0] stg   [OBJ_BYTES];
    logic [7:0] act   [OBJ_BYTES];
    logic [7:0] bmp   [BMP_BYTES];
    logic [5:0] color [NUM_SPRITES];

    logic                   vsync_d;
    logic                   commit;
    logic                   global_en;
    logic                   missed;
    logic [NUM_SPRITES-1:0] coll;
    logic [1:0]             irq_en;

    logic swap;
    logic do_copy;
    assign swap    = vsync & ~vsync_d;
    assign do_copy = swap & commit;

    function automatic logic [2:0] lane_count(input logic [1:0] size_n);
        case (size_n)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    logic [2:0] wr_lanes;
    logic [2:0] rd_lanes;
    logic       rd_req;
    assign wr_lanes = lane_count(data_write_n);
    assign rd_lanes = lane_count(data_read_n);
    assign rd_req   = (data_read_n != 2'b11);

    // Each byte lane is decoded on its own; lanes past 0x3F fall off the map.
    logic [63:0] wen;
    logic [7:0]  wdat [64];
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        logic [6:0] lane_addr;
        lane_addr = '0;
        wen       = '0;
        for (int a = 0; a < 64; a++) wdat[a] = '0;
        for (int k = 0; k < 4; k++) begin
            lane_addr = 7'(address) + 7'(k);
            if (3'(k) < wr_lanes && !lane_addr[6]) begin
                wen[lane_addr[5:0]]  = 1'b1;
                wdat[lane_addr[5:0]] = data_in[8*k +: 8];
            end
        end
    end

    logic [7:0] rmap [64];
    for (genvar a = 0; a < 64; a++) begin : g_rmap
        if (a < BMP_BASE) begin : g_obj
            assign rmap[a] = stg[a];
        end else if (a < COL_BASE) begin : g_bmp
            assign rmap[a] = bmp[a - BMP_BASE];
        end else if (a < COL_END) begin : g_col
            assign rmap[a] = {2'b00, color[a - COL_BASE]};
        end else if (a == ADDR_CTRL) begin : g_ctrl
            assign rmap[a] = {6'b0, global_en, commit};
        end else if (a == ADDR_STATUS) begin : g_status
            assign rmap[a] = {6'b0, |coll, missed};
        end else if (a == ADDR_COLL) begin : g_coll
            assign rmap[a] = 8'(coll);
        end else if (a == ADDR_IRQ_EN) begin : g_irq_en
            assign rmap[a] = {6'b0, irq_en};
        end else begin : g_unmapped
            assign rmap[a] = '0;
        end
    end

    logic [31:0] rd_word;
    always_comb begin
        logic [6:0] lane_addr;
        lane_addr = '0;
        rd_word   = '0;
        for (int k = 0; k < 4; k++) begin
            lane_addr = 7'(address) + 7'(k);
            if (3'(k) < rd_lanes && !lane_addr[6]) begin
                rd_word[8*k +: 8] = rmap[lane_addr[5:0]];
            end
        end
    end

    // Active copies see the pre-write staging value when a write lands on the swap cycle.
    for (genvar j = 0; j < OBJ_BYTES; j++) begin : g_obj_regs
        // NOTE: descriptor, bitmap and colour stores are plain flops, so they are cleared by reset like any register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stg[j] <= '0;
                act[j] <= '0;
            end else begin
                if (wen[j]) stg[j] <= wdat[j];
                if (do_copy) act[j] <= stg[j];
            end
        end
    end

    for (genvar b = 0; b < BMP_BYTES; b++) begin : g_bmp_regs
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bmp[b] <= '0;
            end else if (wen[BMP_BASE + b]) begin
                bmp[b] <= wdat[BMP_BASE + b];
            end
        end
    end

    for (genvar c = 0; c < NUM_SPRITES; c++) begin : g_col_regs
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                color[c] <= '0;
            end else if (wen[COL_BASE + c]) begin
                color[c] <= wdat[COL_BASE + c][5:0];
            end
        end
    end

    // Render: scale pixel coordinates down to the logical sprite grid.
    logic [9:0] px_scaled;
    logic [9:0] py_scaled;
    logic [7:0] lx;
    logic [7:0] ly;
    assign px_scaled = pix_x >> SCALE_SHIFT;
    assign py_scaled = pix_y >> SCALE_SHIFT;
    assign lx        = px_scaled[7:0];
    assign ly        = py_scaled[7:0];

    logic [NUM_SPRITES-1:0] opaque;
    logic [5:0]             pri_rgb [NUM_SPRITES+1];
    assign pri_rgb[NUM_SPRITES] = bg_rgb;

    for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_sprite
        logic [7:0] sx, sy, soff, sattr;
        logic [3:0] sw, sh;
        logic [8:0] x_end, y_end;
        logic       in_x, in_y, in_bmp;
        logic [7:0] dx, dy;
        logic [6:0] bit_idx;
        logic [8:0] byte_addr;
        logic [7:0] bmp_byte;

        assign sx    = act[4*s];
        assign sy    = act[4*s + 1];
        assign soff  = act[4*s + 2];
        assign sattr = act[4*s + 3];
        assign sw    = {1'b0, sattr[5:3]} + 4'd1;
        assign sh    = {1'b0, sattr[2:0]} + 4'd1;

        // Nine-bit end coordinates keep sprites near 255 from wrapping to 0.
        assign x_end = {1'b0, sx} + {5'b0, sw};
        assign y_end = {1'b0, sy} + {5'b0, sh};
        assign in_x  = (lx >= sx) && ({1'b0, lx} < x_end);
        assign in_y  = (ly >= sy) && ({1'b0, ly} < y_end);

        assign dx        = lx - sx;
        assign dy        = ly - sy;
        assign bit_idx   = 7'(dy[2:0]) * 7'(sw) + 7'(dx[2:0]);
        assign byte_addr = {1'b0, soff} + {5'b0, bit_idx[6:3]};
        assign in_bmp    = byte_addr < 9'(BMP_BYTES);
        assign bmp_byte  = in_bmp ? bmp[byte_addr[BA_W-1:0]] : 8'h00;

        assign opaque[s]  = visible & global_en & sattr[7] & in_x & in_y & bmp_byte[bit_idx[2:0]];
        assign pri_rgb[s] = opaque[s] ? color[s] : pri_rgb[s+1];
    end

    // More than one bit set in opaque means at least two sprites overlap here.
    logic                   multi_hit;
    logic [NUM_SPRITES-1:0] coll_set;
    logic [NUM_SPRITES-1:0] coll_clr;
    assign multi_hit = |(opaque & (opaque - NUM_SPRITES'(1)));
    assign coll_set  = multi_hit ? opaque : '0;
    assign coll_clr  = wen[ADDR_COLL] ? wdat[ADDR_COLL][NUM_SPRITES-1:0] : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d        <= 1'b0;
            commit         <= 1'b0;
            global_en      <= 1'b0;
            missed         <= 1'b0;
            coll           <= '0;
            irq_en         <= '0;
            user_interrupt <= 1'b0;
            rgb_out        <= '0;
            data_ready     <= 1'b0;
            data_out       <= '0;
        end else begin
            vsync_d <= vsync;

            // A host write to CTRL on the swap cycle overrides the auto-clear.
            if (wen[ADDR_CTRL]) begin
                commit    <= wdat[ADDR_CTRL][0];
                global_en <= wdat[ADDR_CTRL][1];
            end else if (do_copy) begin
                commit <= 1'b0;
            end

            if (swap && !commit) begin
                missed <= 1'b1;
            end else if (wen[ADDR_STATUS] && wdat[ADDR_STATUS][0]) begin
                missed <= 1'b0;
            end

            coll <= (coll & ~coll_clr) | coll_set;

            if (wen[ADDR_IRQ_EN]) irq_en <= wdat[ADDR_IRQ_EN][1:0];

            user_interrupt <= (missed & irq_en[0]) | ((|coll) & irq_en[1]);
            rgb_out        <= pri_rgb[0];
            data_ready     <= rd_req;
            data_out       <= rd_req ? rd_word : '0;
        end
    end

endmodule
